// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions: ALU control codes, ALUOp encodings and id_ctrl bit positions.
package rv_pipe_pkg;

  // ALU_ctl opcodes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_BLT = 4'b0111;
  localparam logic [3:0] ALU_BGE = 4'b1000;
  localparam logic [3:0] ALU_BNE = 4'b1111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;

  // ALUOp encodings produced by the main decoder
  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  // id_ctrl = {MemRead, MemWrite, RegWrite, MemtoReg, Branch}
  localparam int unsigned CTRL_W        = 5;
  localparam int unsigned CTRL_MEMREAD  = 4;
  localparam int unsigned CTRL_MEMWRITE = 3;
  localparam int unsigned CTRL_REGWRITE = 2;
  localparam int unsigned CTRL_MEMTOREG = 1;
  localparam int unsigned CTRL_BRANCH   = 0;

endpackage

// File: rtl/alu_control.sv
// ALUOp/funct3/funct7_5 -> 4-bit ALU control decode (pure combinational).
module alu_control
  import rv_pipe_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_ctl
);

  // Decode; every unlisted combination falls back to ADD
  always_comb begin
    alu_ctl = ALU_ADD;
    case (alu_op)
      ALUOP_MEM: alu_ctl = ALU_ADD;
      ALUOP_BRANCH: begin
        case (funct3)
          3'b000:  alu_ctl = ALU_SUB;
          3'b001:  alu_ctl = ALU_BNE;
          3'b100:  alu_ctl = ALU_BLT;
          3'b101:  alu_ctl = ALU_BGE;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      ALUOP_RTYPE: begin
        case (funct3)
          3'b000:  alu_ctl = funct7_5 ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctl = ALU_AND;
          3'b110:  alu_ctl = ALU_OR;
          3'b001:  alu_ctl = ALU_SLL;
          3'b101:  alu_ctl = ALU_SRL;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      ALUOP_ITYPE: begin
        // funct7_5 is part of the immediate here, so it is ignored
        case (funct3)
          3'b000:  alu_ctl = ALU_ADD;
          3'b111:  alu_ctl = ALU_AND;
          3'b110:  alu_ctl = ALU_OR;
          3'b001:  alu_ctl = ALU_SLL;
          3'b101:  alu_ctl = ALU_SRL;
          default: alu_ctl = ALU_ADD;
        endcase
      end
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, ALU control decode and
// load-use bubble insertion. Optional perf counters enabled by macro ID_EX_PERF_EN.
module id_ex_stage
  import rv_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
`ifdef ID_EX_PERF_EN
  ,
  parameter int unsigned PERF_W = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic              id_funct7_5,
  input  logic [1:0]        id_ALUOp,
  input  logic              id_ALUSrc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              stall,
  input  logic              exmem_RegWrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [XLEN-1:0]   exmem_alu_out,
  input  logic              memwb_RegWrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [XLEN-1:0]   memwb_wdata,
  output logic              load_use_stall,
  output logic              ex_valid,
  output logic [3:0]        ALU_ctl,
  output logic [XLEN-1:0]   alu_in1,
  output logic [XLEN-1:0]   alu_in2,
  output logic [XLEN-1:0]   ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_branch_target
`ifdef ID_EX_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_bubbles,
  output logic [PERF_W-1:0] perf_stalls
`endif
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [2:0]        funct3;
    logic              funct7_5;
    logic [1:0]        alu_op;
    logic              alu_src;
    logic [CTRL_W-1:0] ctrl;
  } ex_regs_t;

  ex_regs_t ex_q, ex_d;
  logic     load_bubble;
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  // Load-use: the load in EX produces a register the ID instruction reads
  always_comb begin
    load_use_stall = ex_q.valid & ex_q.ctrl[CTRL_MEMREAD] & (ex_q.rd != '0) &
                     ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2)) & id_valid;
  end

  assign load_bubble = flush | (~stall & load_use_stall);

  // Next-state: flush > stall > load-use bubble > capture from ID
  always_comb begin
    ex_d = ex_q;
    if (load_bubble) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d.valid    = id_valid;
      ex_d.pc       = id_pc;
      ex_d.rs1_data = id_rs1_data;
      ex_d.rs2_data = id_rs2_data;
      ex_d.imm      = id_imm;
      ex_d.rs1      = id_rs1;
      ex_d.rs2      = id_rs2;
      ex_d.rd       = id_rd;
      ex_d.funct3   = id_funct3;
      ex_d.funct7_5 = id_funct7_5;
      ex_d.alu_op   = id_ALUOp;
      ex_d.alu_src  = id_ALUSrc;
      ex_d.ctrl     = id_ctrl & {CTRL_W{id_valid}};
    end
  end

  // Stage register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  // Forwarding for rs1: EX/MEM beats MEM/WB, x0 never forwarded
  always_comb begin
    fwd_rs1 = ex_q.rs1_data;
    if (exmem_RegWrite && (exmem_rd != '0) && (exmem_rd == ex_q.rs1)) begin
      fwd_rs1 = exmem_alu_out;
    end else if (memwb_RegWrite && (memwb_rd != '0) && (memwb_rd == ex_q.rs1)) begin
      fwd_rs1 = memwb_wdata;
    end
  end

  // Forwarding for rs2, same rules
  always_comb begin
    fwd_rs2 = ex_q.rs2_data;
    if (exmem_RegWrite && (exmem_rd != '0) && (exmem_rd == ex_q.rs2)) begin
      fwd_rs2 = exmem_alu_out;
    end else if (memwb_RegWrite && (memwb_rd != '0) && (memwb_rd == ex_q.rs2)) begin
      fwd_rs2 = memwb_wdata;
    end
  end

  alu_control u_alu_control (
    .alu_op   (ex_q.alu_op),
    .funct3   (ex_q.funct3),
    .funct7_5 (ex_q.funct7_5),
    .alu_ctl  (ALU_ctl)
  );

  assign ex_valid         = ex_q.valid;
  assign alu_in1          = fwd_rs1;
  assign alu_in2          = ex_q.alu_src ? ex_q.imm : fwd_rs2;
  assign ex_store_data    = fwd_rs2;
  assign ex_rd            = ex_q.rd;
  assign ex_ctrl          = ex_q.ctrl & {CTRL_W{ex_q.valid}};
  assign ex_branch_target = ex_q.pc + ex_q.imm;

`ifdef ID_EX_PERF_EN
  logic [PERF_W-1:0] perf_bubbles_q, perf_stalls_q;
  logic              stall_hold;

  assign stall_hold = stall & ~flush;

  // Saturating event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_bubbles_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      if (load_bubble && (perf_bubbles_q != '1)) perf_bubbles_q <= perf_bubbles_q + 1'b1;
      if (stall_hold && (perf_stalls_q != '1)) perf_stalls_q <= perf_stalls_q + 1'b1;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: decode table, hand-written hazard/forwarding/reset
// sequences, then randomized traffic against a behavioural model of the EX slot.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_funct7_5;
  logic [1:0]  id_ALUOp;
  logic        id_ALUSrc;
  logic [4:0]  id_ctrl;
  logic        flush, stall;
  logic        exmem_RegWrite, memwb_RegWrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_alu_out, memwb_wdata;
  logic        load_use_stall, ex_valid;
  logic [3:0]  ALU_ctl;
  logic [31:0] alu_in1, alu_in2, ex_store_data, ex_branch_target;
  logic [4:0]  ex_rd, ex_ctrl;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubbles, perf_stalls;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk              (clk),
    .reset            (reset),
    .id_valid         (id_valid),
    .id_pc            (id_pc),
    .id_rs1_data      (id_rs1_data),
    .id_rs2_data      (id_rs2_data),
    .id_imm           (id_imm),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rd            (id_rd),
    .id_funct3        (id_funct3),
    .id_funct7_5      (id_funct7_5),
    .id_ALUOp         (id_ALUOp),
    .id_ALUSrc        (id_ALUSrc),
    .id_ctrl          (id_ctrl),
    .flush            (flush),
    .stall            (stall),
    .exmem_RegWrite   (exmem_RegWrite),
    .exmem_rd         (exmem_rd),
    .exmem_alu_out    (exmem_alu_out),
    .memwb_RegWrite   (memwb_RegWrite),
    .memwb_rd         (memwb_rd),
    .memwb_wdata      (memwb_wdata),
    .load_use_stall   (load_use_stall),
    .ex_valid         (ex_valid),
    .ALU_ctl          (ALU_ctl),
    .alu_in1          (alu_in1),
    .alu_in2          (alu_in2),
    .ex_store_data    (ex_store_data),
    .ex_rd            (ex_rd),
    .ex_ctrl          (ex_ctrl),
    .ex_branch_target (ex_branch_target)
`ifdef ID_EX_PERF_EN
    ,
    .perf_bubbles     (perf_bubbles),
    .perf_stalls      (perf_stalls)
`endif
  );

  // Model of the instruction occupying EX
  typedef struct packed {
    logic        v;
    logic [31:0] pc, r1, r2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [1:0]  op;
    logic        src;
    logic [4:0]  ctrl;
  } ex_t;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] f3;
    logic       f7;
    logic [3:0] exp;
  } dec_vec_t;

  ex_t m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_funct3 = 0; id_funct7_5 = 0;
    id_ALUOp = 0; id_ALUSrc = 0; id_ctrl = 0; flush = 0; stall = 0;
    exmem_RegWrite = 0; exmem_rd = 0; exmem_alu_out = 0;
    memwb_RegWrite = 0; memwb_rd = 0; memwb_wdata = 0;
  endtask

  // ALU control table from the instruction-set encoding
  function automatic logic [3:0] ref_ctl(input logic [1:0] op, input logic [2:0] f3,
                                         input logic f7);
    logic [3:0] r;
    r = 4'b0010;
    if (op == 2'b01) begin
      if (f3 == 3'd0) r = 4'b0110;
      else if (f3 == 3'd1) r = 4'b1111;
      else if (f3 == 3'd4) r = 4'b0111;
      else if (f3 == 3'd5) r = 4'b1000;
    end else if (op[1]) begin
      if (f3 == 3'd0) r = (op == 2'b10 && f7) ? 4'b0110 : 4'b0010;
      else if (f3 == 3'd7) r = 4'b0000;
      else if (f3 == 3'd6) r = 4'b0001;
      else if (f3 == 3'd1) r = 4'b1001;
      else if (f3 == 3'd5) r = 4'b1010;
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rf);
    if (exmem_RegWrite && exmem_rd != 0 && exmem_rd == rs) return exmem_alu_out;
    if (memwb_RegWrite && memwb_rd != 0 && memwb_rd == rs) return memwb_wdata;
    return rf;
  endfunction

  dec_vec_t dec_tab[15];

  initial begin
    logic exp_lus;
    logic [31:0] f2;
    int pb, ps;

    dec_tab[0]  = '{op: 2'b10, f3: 3'b000, f7: 1'b1, exp: 4'b0110};
    dec_tab[1]  = '{op: 2'b01, f3: 3'b001, f7: 1'b0, exp: 4'b1111};
    dec_tab[2]  = '{op: 2'b11, f3: 3'b010, f7: 1'b0, exp: 4'b0010};
    dec_tab[3]  = '{op: 2'b10, f3: 3'b000, f7: 1'b0, exp: 4'b0010};
    dec_tab[4]  = '{op: 2'b10, f3: 3'b111, f7: 1'b0, exp: 4'b0000};
    dec_tab[5]  = '{op: 2'b10, f3: 3'b110, f7: 1'b0, exp: 4'b0001};
    dec_tab[6]  = '{op: 2'b10, f3: 3'b001, f7: 1'b0, exp: 4'b1001};
    dec_tab[7]  = '{op: 2'b10, f3: 3'b101, f7: 1'b1, exp: 4'b1010};
    dec_tab[8]  = '{op: 2'b01, f3: 3'b000, f7: 1'b0, exp: 4'b0110};
    dec_tab[9]  = '{op: 2'b01, f3: 3'b100, f7: 1'b0, exp: 4'b0111};
    dec_tab[10] = '{op: 2'b01, f3: 3'b101, f7: 1'b0, exp: 4'b1000};
    dec_tab[11] = '{op: 2'b00, f3: 3'b111, f7: 1'b1, exp: 4'b0010};
    dec_tab[12] = '{op: 2'b11, f3: 3'b000, f7: 1'b1, exp: 4'b0010};
    dec_tab[13] = '{op: 2'b01, f3: 3'b010, f7: 1'b0, exp: 4'b0010};
    dec_tab[14] = '{op: 2'b11, f3: 3'b110, f7: 1'b1, exp: 4'b0001};

    reset = 1;
    idle();
    #2;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_ex_ctrl", 32'(ex_ctrl), 32'd0);
    chk("rst_alu_ctl", 32'(ALU_ctl), 32'd2);
    chk("rst_branch_target", ex_branch_target, 32'd0);
    chk("rst_load_use", 32'(load_use_stall), 32'd0);
    #10;
    reset = 0;

    // Decode table
    for (int i = 0; i < 15; i++) begin
      id_valid = 1; id_ALUOp = dec_tab[i].op; id_funct3 = dec_tab[i].f3;
      id_funct7_5 = dec_tab[i].f7;
      tick();
      chk($sformatf("alu_ctl_vec%0d", i), 32'(ALU_ctl), 32'(dec_tab[i].exp));
    end

    // Load then dependent add
    idle();
    id_valid = 1; id_rs1 = 2; id_rd = 5; id_ALUSrc = 1; id_imm = 4; id_ctrl = 5'b10110;
    tick();
    id_rs1 = 5; id_rs2 = 1; id_rd = 6; id_ALUOp = 2'b10; id_ALUSrc = 0; id_imm = 0;
    id_ctrl = 5'b00100; id_rs1_data = 32'hDEADBEEF; id_rs2_data = 32'd7;
    #1;
    chk("lu_stall_asserted", 32'(load_use_stall), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_ctrl", 32'(ex_ctrl), 32'd0);
    chk("lu_stall_one_cycle", 32'(load_use_stall), 32'd0);
    memwb_RegWrite = 1; memwb_rd = 5; memwb_wdata = 32'h12345678;
    tick();
    chk("lu_add_valid", 32'(ex_valid), 32'd1);
    chk("lu_add_rd", 32'(ex_rd), 32'd6);
    chk("lu_add_in1_memwb", alu_in1, 32'h12345678);
    chk("lu_add_in2", alu_in2, 32'd7);

    // Forwarding priority and x0
    idle();
    id_valid = 1; id_rs1 = 3; id_rs2 = 3; id_rs1_data = 32'h11111111;
    id_rs2_data = 32'h33333333; id_ALUOp = 2'b10; id_ctrl = 5'b00100;
    tick();
    exmem_RegWrite = 1; exmem_rd = 3; exmem_alu_out = 32'hAAAA0000;
    memwb_RegWrite = 1; memwb_rd = 3; memwb_wdata = 32'h5555FFFF;
    #1;
    chk("fwd_both_in1", alu_in1, 32'hAAAA0000);
    chk("fwd_both_in2", alu_in2, 32'hAAAA0000);
    exmem_RegWrite = 0;
    #1;
    chk("fwd_memwb_in1", alu_in1, 32'h5555FFFF);
    exmem_RegWrite = 1; exmem_rd = 0; memwb_rd = 0;
    #1;
    chk("fwd_rd0_in1", alu_in1, 32'h11111111);
    chk("fwd_rd0_store", ex_store_data, 32'h33333333);
    id_rs1 = 0; id_rs2 = 3; id_rs1_data = 32'h22222222; id_ALUSrc = 1; id_imm = 32'h40;
    tick();
    exmem_rd = 3;
    #1;
    chk("fwd_x0_in1", alu_in1, 32'h22222222);
    chk("imm_in2", alu_in2, 32'h40);
    chk("imm_store_fwd", ex_store_data, 32'hAAAA0000);

    // Flush and stall together
    idle();
    id_valid = 1; id_rd = 4; id_ctrl = 5'b00100;
    tick();
    flush = 1; stall = 1; id_ctrl = 5'b11111;
    tick();
    chk("flush_stall_valid", 32'(ex_valid), 32'd0);
    chk("flush_stall_ctrl", 32'(ex_ctrl), 32'd0);

    // Stall holds
    idle();
    id_valid = 1; id_rd = 9; id_ctrl = 5'b00100;
    tick();
    id_rd = 10; stall = 1;
    tick();
    chk("stall_hold_rd", 32'(ex_rd), 32'd9);
    chk("stall_hold_valid", 32'(ex_valid), 32'd1);
    stall = 0;
    tick();
    chk("stall_release_rd", 32'(ex_rd), 32'd10);

    // Branch target wrap
    idle();
    id_valid = 1; id_pc = 32'hFFFFFFF0; id_imm = 32'h20; id_ctrl = 5'b00001;
    tick();
    chk("branch_wrap", ex_branch_target, 32'h00000010);

    // Async reset between edges
    idle();
    id_valid = 1; id_pc = 32'h100; id_ALUOp = 2'b10; id_funct3 = 3'b111; id_ctrl = 5'b00110;
    tick();
    chk("pre_reset_valid", 32'(ex_valid), 32'd1);
    #1 reset = 1;
    #1;
    chk("async_rst_valid", 32'(ex_valid), 32'd0);
    chk("async_rst_ctrl", 32'(ex_ctrl), 32'd0);
    chk("async_rst_alu_ctl", 32'(ALU_ctl), 32'd2);
    chk("async_rst_target", ex_branch_target, 32'd0);
    #1 reset = 0;

    // Randomized traffic against the model
    m = '0; pb = 0; ps = 0;
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3)); id_funct3 = 3'($urandom_range(0, 7));
      id_funct7_5 = 1'($urandom_range(0, 1)); id_ALUOp = 2'($urandom_range(0, 3));
      id_ALUSrc = 1'($urandom_range(0, 1)); id_ctrl = 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 9) == 0); stall = ($urandom_range(0, 7) == 0);
      exmem_RegWrite = 1'($urandom_range(0, 1)); exmem_rd = 5'($urandom_range(0, 3));
      exmem_alu_out = $urandom;
      memwb_RegWrite = 1'($urandom_range(0, 1)); memwb_rd = 5'($urandom_range(0, 3));
      memwb_wdata = $urandom;
      #1;
      exp_lus = m.v && m.ctrl[4] && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2) && id_valid;
      f2 = ref_fwd(m.rs2, m.r2);
      chk("rnd_load_use", 32'(load_use_stall), 32'(exp_lus));
      chk("rnd_ex_valid", 32'(ex_valid), 32'(m.v));
      chk("rnd_ex_ctrl", 32'(ex_ctrl), m.v ? 32'(m.ctrl) : 32'd0);
      chk("rnd_ex_rd", 32'(ex_rd), 32'(m.rd));
      chk("rnd_alu_ctl", 32'(ALU_ctl), 32'(ref_ctl(m.op, m.f3, m.f7)));
      chk("rnd_alu_in1", alu_in1, ref_fwd(m.rs1, m.r1));
      chk("rnd_alu_in2", alu_in2, m.src ? m.imm : f2);
      chk("rnd_store_data", ex_store_data, f2);
      chk("rnd_branch_target", ex_branch_target, m.pc + m.imm);
`ifdef ID_EX_PERF_EN
      chk("rnd_perf_bubbles", perf_bubbles, 32'(pb));
      chk("rnd_perf_stalls", perf_stalls, 32'(ps));
`endif
      if (flush || (!stall && exp_lus)) pb++;
      if (stall && !flush) ps++;
      if (flush || (!stall && exp_lus)) begin
        m = '0;
      end else if (!stall) begin
        m.v = id_valid; m.pc = id_pc; m.r1 = id_rs1_data; m.r2 = id_rs2_data;
        m.imm = id_imm; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd; m.f3 = id_funct3;
        m.f7 = id_funct7_5; m.op = id_ALUOp; m.src = id_ALUSrc;
        m.ctrl = id_valid ? id_ctrl : 5'd0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
